// File: rtl/gshare_bht.sv
// gshare_bht
// Two-slot gshare branch predictor for the fetch stage.
// Each fetch slot is predicted from a table of saturating counters. The table
// is indexed by PC[IDX_BITS+1:2] XORed with the global branch history (BHR).
// Counters are trained at retire with the history captured at prediction time.
// The BHR is restored from the ROB on recovery. After every reset, a sweep
// writes CTR_INIT to every entry. Because of this sweep, the counter array
// itself has no reset.
//
// Ports
//   clock, reset              rising-edge clock, asynchronous active-low reset
//   if_valid_cond0/1          fetch slot holds a conditional branch
//   if_NPC0/1                 fetch slot PC used for indexing
//   if_stall                  fetch stalled, history does not advance
//   recover_cond, recover_bhr ROB recovery and the history to restore
//   rob_retire_num            retiring instruction count (3 acts as 2)
//   rob_retire_cond0/1        retiring slot is a conditional branch
//   rob_retire_NPC0/1         retiring branch PC
//   rob_retire_BHR0/1         history used when that branch was predicted
//   rob_actual_taken0/1       resolved direction
//   rob_pred_taken0/1         predicted direction (performance counters only)
//   if_branch_taken0/1        combinational prediction per slot
//   id_bhr0/1                 history used for each slot, passed on to ID
//   bht_ready                 initialisation sweep finished
//   perf_cond_retired         trained branch count   (BHT_PERF_EN only)
//   perf_mispred              mispredicted branch count (BHT_PERF_EN only)
//
// Optional feature: define BHT_PERF_EN to add the two 32-bit perf counters.

module gshare_bht #(
   parameter int IDX_BITS  = 6,
   parameter int HIST_BITS = 6,
   parameter int CTR_BITS  = 2,
   parameter int CTR_INIT  = (1 << (CTR_BITS - 1)) - 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 if_valid_cond0,
   input  logic                 if_valid_cond1,
   input  logic [63:0]          if_NPC0,
   input  logic [63:0]          if_NPC1,
   input  logic                 if_stall,
   input  logic                 recover_cond,
   input  logic [HIST_BITS-1:0] recover_bhr,
   input  logic [1:0]           rob_retire_num,
   input  logic                 rob_retire_cond0,
   input  logic                 rob_retire_cond1,
   input  logic [63:0]          rob_retire_NPC0,
   input  logic [63:0]          rob_retire_NPC1,
   input  logic [HIST_BITS-1:0] rob_retire_BHR0,
   input  logic [HIST_BITS-1:0] rob_retire_BHR1,
   input  logic                 rob_actual_taken0,
   input  logic                 rob_actual_taken1,
   input  logic                 rob_pred_taken0,
   input  logic                 rob_pred_taken1,
   output logic                 if_branch_taken0,
   output logic                 if_branch_taken1,
   output logic [HIST_BITS-1:0] id_bhr0,
   output logic [HIST_BITS-1:0] id_bhr1,
   output logic                 bht_ready
`ifdef BHT_PERF_EN
   ,
   output logic [31:0]          perf_cond_retired,
   output logic [31:0]          perf_mispred
`endif
);

   localparam int ENTRIES = 1 << IDX_BITS;

   typedef enum logic {INIT, RUN} state_t;

   state_t                state, state_next;
   logic [IDX_BITS-1:0]   init_ptr;
   logic [HIST_BITS-1:0]  bhr, bhr_next, bhr_fetch, h1;
   logic [CTR_BITS-1:0]   ctr_mem [ENTRIES];

   logic [IDX_BITS-1:0]   idx0, idx1, ridx0, ridx1;
   logic                  raw_taken0, raw_taken1, slot0_taken;
   logic                  upd_en, upd0, upd1;
   logic [CTR_BITS-1:0]   new0, base1, new1;

   // Table index: PC word bits XORed with the zero-extended history.
   function automatic logic [IDX_BITS-1:0] tbl_idx(input logic [63:0] pc,
                                                   input logic [HIST_BITS-1:0] h);
      return pc[IDX_BITS+1:2] ^ IDX_BITS'(h);
   endfunction

   // Shift one outcome into the history. The oldest bit falls off the top.
   function automatic logic [HIST_BITS-1:0] hist_push(input logic [HIST_BITS-1:0] h,
                                                      input logic b);
      return HIST_BITS'({h, b});
   endfunction

   // One saturating counter step toward the resolved direction.
   function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c,
                                                    input logic up);
      if (up)
         return (c == '1) ? c : c + CTR_BITS'(1);
      else
         return (c == '0) ? c : c - CTR_BITS'(1);
   endfunction

   assign bht_ready = (state == RUN);

   // Prediction path.
   // Slot 1 sees the history that slot 0 produced.
   // A taken slot 0 ends the fetch group, so slot 1 is then ignored.
   // During INIT the table is not yet valid. raw_taken0 is therefore
   // qualified by bht_ready so that the history outputs stay at BHR.
   always_comb begin
      idx0       = tbl_idx(if_NPC0, bhr);
      raw_taken0 = if_valid_cond0 & ctr_mem[idx0][CTR_BITS-1];
      slot0_taken = bht_ready & raw_taken0;
      h1         = if_valid_cond0 ? hist_push(bhr, 1'b0) : bhr;
      idx1       = tbl_idx(if_NPC1, h1);
      raw_taken1 = if_valid_cond1 & ctr_mem[idx1][CTR_BITS-1];

      if_branch_taken0 = 1'b0;
      if_branch_taken1 = 1'b0;
      id_bhr0          = bhr;
      id_bhr1          = bhr;
      bhr_fetch        = bhr;

      if (bht_ready) begin
         if_branch_taken0 = ~recover_cond & raw_taken0;
         if (slot0_taken) begin
            id_bhr1   = hist_push(bhr, 1'b1);
            bhr_fetch = id_bhr1;
         end else begin
            if_branch_taken1 = ~recover_cond & raw_taken1;
            id_bhr1          = h1;
            bhr_fetch        = if_valid_cond1 ? hist_push(h1, raw_taken1) : h1;
         end
      end
   end

   // Next history.
   // Recovery overrides everything, including a stall.
   // Fetch only advances the history while running and not stalled.
   always_comb begin
      bhr_next = bhr;
      if (recover_cond)
         bhr_next = recover_bhr;
      else if (bht_ready && !if_stall)
         bhr_next = bhr_fetch;
   end

   // Retire training.
   // When both slots hit one entry, slot 1 steps from slot 0's result, so
   // each step saturates on its own.
   always_comb begin
      upd_en = bht_ready & ~recover_cond;
      upd0   = upd_en & (|rob_retire_num) & rob_retire_cond0;
      upd1   = upd_en & rob_retire_num[1] & rob_retire_cond1;
      ridx0  = tbl_idx(rob_retire_NPC0, rob_retire_BHR0);
      ridx1  = tbl_idx(rob_retire_NPC1, rob_retire_BHR1);
      new0   = sat_step(ctr_mem[ridx0], rob_actual_taken0);
      base1  = (upd0 && (ridx0 == ridx1)) ? new0 : ctr_mem[ridx1];
      new1   = sat_step(base1, rob_actual_taken1);
   end

   // Sweep FSM: leave INIT once the last entry has been written.
   always_comb begin
      state_next = state;
      unique case (state)
         INIT: if (init_ptr == IDX_BITS'(ENTRIES - 1)) state_next = RUN;
         RUN:  state_next = RUN;
         default: state_next = INIT;
      endcase
   end

   // State, sweep pointer and history registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= INIT;
         init_ptr <= '0;
         bhr      <= '0;
      end else begin
         state <= state_next;
         bhr   <= bhr_next;
         if (state == INIT)
            init_ptr <= init_ptr + IDX_BITS'(1);
      end
   end

   // Counter array without reset.
   // It is written by the sweep during INIT and by retire training in RUN.
   // If both slots hit the same entry, the later slot-1 write holds the
   // combined result.
   always_ff @(posedge clock) begin
      if (state == INIT) begin
         ctr_mem[init_ptr] <= CTR_BITS'(CTR_INIT);
      end else begin
         if (upd0) ctr_mem[ridx0] <= new0;
         if (upd1) ctr_mem[ridx1] <= new1;
      end
   end

`ifdef BHT_PERF_EN
   // Performance counters count only the slots that actually trained the table.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_cond_retired <= '0;
         perf_mispred      <= '0;
      end else begin
         perf_cond_retired <= perf_cond_retired + 32'(upd0) + 32'(upd1);
         perf_mispred      <= perf_mispred
                              + 32'(upd0 & (rob_pred_taken0 != rob_actual_taken0))
                              + 32'(upd1 & (rob_pred_taken1 != rob_actual_taken1));
      end
   end

   // PC bits outside the index field do not affect the predictor.
   logic unused_bits;
   assign unused_bits = ^{if_NPC0[63:IDX_BITS+2], if_NPC0[1:0],
                          if_NPC1[63:IDX_BITS+2], if_NPC1[1:0],
                          rob_retire_NPC0[63:IDX_BITS+2], rob_retire_NPC0[1:0],
                          rob_retire_NPC1[63:IDX_BITS+2], rob_retire_NPC1[1:0]};
`else
   // PC bits outside the index field, and the predicted direction, do not
   // affect the predictor when the perf counters are absent.
   logic unused_bits;
   assign unused_bits = ^{if_NPC0[63:IDX_BITS+2], if_NPC0[1:0],
                          if_NPC1[63:IDX_BITS+2], if_NPC1[1:0],
                          rob_retire_NPC0[63:IDX_BITS+2], rob_retire_NPC0[1:0],
                          rob_retire_NPC1[63:IDX_BITS+2], rob_retire_NPC1[1:0],
                          rob_pred_taken0, rob_pred_taken1};
`endif

endmodule

// File: doc/gshare_bht.md
# gshare_bht

Parametrised two-slot gshare branch predictor for the fetch stage. It supersedes the fixed 64-entry, 6-bit-history predictor. It predicts up to two conditional branches per cycle from a global history register (BHR) XORed with the fetch PC, and hands the per-slot history to ID for ROB storage. Counters are updated at retire, and the BHR is restored on ROB recovery. A post-reset sweep FSM initialises the table, so the counter array needs no reset fan-out.

## Interface
- IDX_BITS, 6: table has 2^IDX_BITS counters; index = NPC[IDX_BITS+1:2] ^ zero-extended history.
- HIST_BITS, 6: BHR width; must be ≤ IDX_BITS.
- CTR_BITS, 2: saturating counter width; prediction = counter MSB.
- CTR_INIT, 2^(CTR_BITS-1)-1: value written by the init sweep (weakly not-taken).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- if_valid_cond0 / if_valid_cond1  in  1  fetch slot holds a conditional branch.
- if_NPC0 / if_NPC1  in  64  slot PC used for indexing.
- if_stall  in  1  fetch stalled; BHR does not advance.
- recover_cond  in  1  ROB mispredict/exception recovery.
- recover_bhr  in  HIST_BITS  history to restore.
- rob_retire_num  in  2  number of retiring instructions (0–2; 3 is treated as 2).
- rob_retire_cond0/1  in  1  retiring slot is a conditional branch.
- rob_retire_NPC0/1  in  64  PC of the retiring branch.
- rob_retire_BHR0/1  in  HIST_BITS  history captured at prediction.
- rob_actual_taken0/1  in  1  resolved direction.
- rob_pred_taken0/1  in  1  predicted direction (used only under BHT_PERF_EN).
- if_branch_taken0/1  out  1  prediction, combinational.
- id_bhr0/1  out  HIST_BITS  history used for each slot, combinational.
- bht_ready  out  1  init sweep complete.

## Operation
- FSM states are INIT and RUN.
- Reset asserted: state = INIT, init_ptr = 0, BHR = 0.
- INIT:
  - Writes CTR_INIT to entry init_ptr each cycle and increments init_ptr.
  - After writing entry 2^IDX_BITS-1, moves to RUN.
  - bht_ready = 0; both predictions = 0; retire updates are dropped; BHR holds except on recover.
- RUN, prediction (recover_cond = 0):
  - Slot 0 valid: taken0 = MSB of ctr[NPC0 idx ^ BHR]; id_bhr0 = BHR.
  - Slot 0 taken: slot 1 is ignored (taken1 = 0); next BHR = {BHR, 1}; id_bhr1 = next BHR.
  - Slot 0 not taken or invalid: H1 = {BHR, 0} if slot 0 valid, else BHR.
    - taken1 = MSB of ctr[NPC1 idx ^ H1]; id_bhr1 = H1.
    - Next BHR = {H1, taken1} if slot 1 valid, else H1.
  - Neither slot valid: BHR holds; id_bhr0 = id_bhr1 = BHR.
  - if_stall = 1: outputs are still driven, but BHR holds.
- Recovery, recover_cond = 1 in either state:
  - Next BHR = recover_bhr; predictions forced to 0.
  - All retire updates in the same cycle are dropped.
  - Recovery takes priority over if_stall.
- Retire update (RUN, no recover):
  - Slot 0 updates when rob_retire_num ≥ 1 and rob_retire_cond0 = 1.
  - Slot 1 updates when rob_retire_num ≥ 2 and rob_retire_cond1 = 1.
  - Index = NPC[IDX_BITS+1:2] ^ retire BHR; counter +1 if taken, -1 if not taken, saturating at 0 and 2^CTR_BITS-1.
  - Both slots hit the same index: apply slot 0 then slot 1, each step saturating.
- Predictions read the registered table; no bypass from a same-cycle retire write.

## Timing
- Predictions and id_bhr are combinational from the current BHR and NPC (zero-cycle latency).
- BHR and counter writes take effect at the next rising edge; a retire update is visible to predictions one cycle later.
- Reset values: bht_ready = 0, BHR = 0, if_branch_taken0/1 = 0, id_bhr0/1 = 0.
- bht_ready rises exactly 2^IDX_BITS cycles after reset deassertion.
- Reset asserted mid-INIT restarts the sweep at entry 0.
- Reset asserted during RUN returns the FSM to INIT.
- BHR shifts discard the MSB; there is no wrap state.

## Configuration
- BHT_PERF_EN defined adds outputs perf_cond_retired[31:0] and perf_mispred[31:0].
  - Both are asynchronously reset to 0 and wrap at 2^32.
  - perf_cond_retired increments by the number of slots updated this cycle (0–2).
  - perf_mispred increments by the number of updated slots where rob_pred_taken ≠ rob_actual_taken.
  - Slots dropped by recovery or INIT are not counted.
- BHT_PERF_EN undefined: the ports, counters and rob_pred_taken usage are absent; prediction behaviour is identical.

## Test plan
- Reset release, defaults: bht_ready low for 64 cycles then high; NPC0 = 0x100 valid → taken0 = 0, id_bhr0 = 0.
- Training:
  - Retire slot 0 twice with NPC = 0x100, BHR = 0, taken → entry 0 reaches 3.
  - Then fetch NPC0 = 0x100 → taken0 = 1; next-cycle BHR = 0x01.
- Dual slot, BHR = 0x01, slot 0 weak not-taken, slot 1 index ^ 0x02 trained to 3:
  - Outputs: taken0 = 0, taken1 = 1, id_bhr0 = 0x01, id_bhr1 = 0x02.
  - Next BHR = 0x05.
- Recovery with a same-cycle dual retire: recover_bhr = 0x2A → next BHR = 0x2A, table unchanged, predictions 0.
- Same-index dual retire:
  - Counter 2, both taken → 3.
  - Counter 1, both not-taken → 0.
  - Counter 3, taken then not-taken → 2.
- Mid-INIT reset and perf counters (BHT_PERF_EN):
  - Reset at sweep cycle 30 → bht_ready rises 64 cycles after the new release.
  - Two retires, one mispredicted → perf_cond_retired = 2, perf_mispred = 1.
